// File: rtl/rr_reg_arbiter.sv
// ============================================================================
//  Module   : rr_reg_arbiter
//  Purpose  : Round-robin arbitration of N writers onto one shared W-bit
//             register. Optional ownership lock is enabled by RR_ARB_LOCK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_reg_arbiter #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef RR_ARB_LOCK_EN
    input  logic                 lock,
`endif
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       wdata,
    output logic [N-1:0]         gnt,
    output logic [W-1:0]         q,
    output logic                 q_valid,
    output logic [$clog2(N)-1:0] owner
);

    localparam int c_PW = $clog2(N);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t            r_state;
    logic [c_PW-1:0]   r_ptr;
    logic [N-1:0]      w_req_eff;
    logic              w_found;
    logic [c_PW-1:0]   w_winner;
    logic [c_PW-1:0]   w_idx;
    logic [c_PW-1:0]   w_next_ptr;

`ifdef RR_ARB_LOCK_EN
    logic              r_locked;

    // While locked, only the current owner may win the register.
    always_comb begin
        w_req_eff = req;
        if (r_locked) begin
            w_req_eff = req & (N'(1) << owner);
        end
    end
`else
    always_comb begin
        w_req_eff = req;
    end
`endif

    // First set request at or above the pointer, wrapping modulo N.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = c_PW'((int'(r_ptr) + k) % N);
            if (!w_found && w_req_eff[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_next_ptr = (w_winner == c_PW'(N - 1)) ? '0 : w_winner + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            gnt      <= '0;
            q        <= '0;
            q_valid  <= 1'b0;
            owner    <= '0;
`ifdef RR_ARB_LOCK_EN
            r_locked <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        q        <= wdata[int'(w_winner)*W +: W];
                        owner    <= w_winner;
                        q_valid  <= 1'b1;
                        gnt      <= N'(1) << w_winner;
                        r_ptr    <= w_next_ptr;
`ifdef RR_ARB_LOCK_EN
                        r_locked <= lock;
`endif
                        r_state  <= ST_GRANT;
                    end else begin
                        gnt <= '0;
                    end
                end
                ST_GRANT: begin
                    // Recovery cycle: requests are ignored so each writer sees one gnt pulse.
                    gnt     <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    gnt     <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/rr_reg_arbiter.md
RR_REG_ARBITER -- requirements
Module: rr_reg_arbiter

Interface
REQ-001 Parameter N, 4, number of requesters (2..8).
REQ-002 Parameter W, 8, shared register data width.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high; takes effect on posedge rst without a clock edge.
REQ-005 req  input  N  per-requester write request, bit i = requester i.
REQ-006 wdata  input  N*W  write data, requester i on bits [i*W +: W].
REQ-007 gnt  output  N  registered one-hot grant, high for exactly one cycle per accepted write.
REQ-008 q  output  W  shared register contents.
REQ-009 q_valid  output  1  high once q has been written since reset.
REQ-010 owner  output  clog2(N)  index of the requester that last wrote q.
REQ-011 lock  input  1  hold ownership; present only when RR_ARB_LOCK_EN is defined.

Function
REQ-012 The block SHALL implement a two-state FSM, IDLE and GRANT.
REQ-013 In IDLE with req == 0, the block SHALL stay in IDLE, keep gnt = 0, and hold q, owner and q_valid.
REQ-014 In IDLE with req != 0, the block SHALL pick the winner as the first set req bit found by searching upward from pointer ptr, modulo N.
REQ-015 On that same edge the block SHALL load q with the winner's wdata, set owner to the winner, set q_valid = 1, drive gnt one-hot on the winner and enter GRANT.
REQ-016 On the same edge ptr SHALL advance to (winner+1) mod N, wrapping from N-1 to 0.
REQ-017 In GRANT the block SHALL clear gnt to 0, ignore all req, hold q, owner, q_valid and ptr, and return to IDLE on the next edge.
REQ-018 Latency: req sampled at edge k SHALL produce q updated and gnt high after edge k. Sustained throughput SHALL be at most one write per two cycles.
REQ-019 A requester SHALL drop req during its gnt cycle. A req still high in the following IDLE cycle SHALL be treated as a new request.
REQ-020 With all req bits high continuously, grants SHALL rotate 0,1,...,N-1,0 with no requester skipped.
REQ-021 wdata of non-winning requesters SHALL have no effect.
REQ-022 gnt SHALL never have more than one bit set.

Reset
REQ-023 Asserting rst SHALL immediately set state = IDLE, gnt = 0, q = 0, q_valid = 0, owner = 0, ptr = 0 (and locked = 0 when RR_ARB_LOCK_EN is defined).
REQ-024 rst asserted during GRANT SHALL abort the grant cycle; gnt SHALL fall with rst, not at the next clock edge.
REQ-025 While rst is high, all outputs SHALL hold their reset values regardless of clk and req.
REQ-026 After rst deasserts, the first posedge clk SHALL evaluate req normally from IDLE.

Configuration
REQ-027 With macro RR_ARB_LOCK_EN defined, the lock port SHALL exist.
REQ-028 With RR_ARB_LOCK_EN defined, a grant made while lock = 1 SHALL set a locked flag. While locked, IDLE SHALL consider only req[owner], and other requests SHALL wait.
REQ-029 With RR_ARB_LOCK_EN defined, a grant to owner with lock = 0 SHALL clear the locked flag and resume round-robin from ptr.
REQ-030 Without RR_ARB_LOCK_EN, the lock port and locked flag SHALL be absent and arbitration SHALL be pure round-robin.

Verification
REQ-031 Reset check: rst = 1 mid-GRANT at t = 12 ns (no clk edge) -> gnt = 0, q = 0, q_valid = 0, owner = 0 immediately.
REQ-032 Single requester: req = 4'b0100, wdata[23:16] = 8'hA5 -> after the next edge q = 8'hA5, gnt = 4'b0100 for one cycle, owner = 2, q_valid = 1.
REQ-033 Full contention: req = 4'b1111 held for 8 cycles after reset -> gnt sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000.
REQ-034 Wrap-around: ptr = 3, req = 4'b0011 -> grant goes to requester 0, then ptr = 1.
REQ-035 Held req: req[1] kept high through GRANT -> no grant in the GRANT cycle, then requester 1 is granted again in the next IDLE.
REQ-036 Lock (RR_ARB_LOCK_EN): requester 1 granted with lock = 1, req = 4'b1111 -> the next two grants both go to requester 1. A grant with lock = 0 then resumes the rotation at requester 2.
